// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shifter.
//   mode_e   : operation selector (SLL, SRL, SRA, ROL)
//   MODE_W   : width of the mode field
//   grp_lo/grp_hi : which shift-amount bits a given pipeline stage handles.
//                   Groups are contiguous, LSB group first; the last stage
//                   absorbs any remainder bits.
package shift_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_SLL = 2'd0,
    MODE_SRL = 2'd1,
    MODE_SRA = 2'd2,
    MODE_ROL = 2'd3
  } mode_e;

  // Lowest amount bit handled by stage idx.
  function automatic int grp_lo(input int shw, input int stages, input int idx);
    return idx * (shw / stages);
  endfunction

  // Highest amount bit handled by stage idx.
  function automatic int grp_hi(input int shw, input int stages, input int idx);
    if (idx == stages - 1) return shw - 1;
    return (idx + 1) * (shw / stages) - 1;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the shifter: partial shift by amount bits [HI:LO],
// carry update, and a register set with valid/ready control.
//
// Handshake: a beat moves on a clock edge when the producer's valid and the
// consumer's ready are both high. up_ready = !valid || dn_ready, so a stage
// accepts when it is empty or its content leaves this same edge. While a
// stage is full and dn_ready is low its registers are frozen.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   up_valid/up_ready          upstream handshake
//   up_data/up_mode/up_amt     operand, mode and full shift amount
//   up_carry                   carry produced by earlier stages
//   dn_ready                   downstream ready
//   valid, data, mode, amt     registered stage outputs
//   carry, zero                registered carry and data==0 flag
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LO    = 0,
  parameter int HI    = 0,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  mode_e            up_mode,
  input  logic [SHW-1:0]   up_amt,
  input  logic             up_carry,
  input  logic             dn_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output mode_e            mode,
  output logic [SHW-1:0]   amt,
  output logic             carry,
  output logic             zero
);

  logic [SHW-1:0]   s;        // this stage's partial shift amount
  logic [SHW-1:0]   idx_l;    // WIDTH - s (mod WIDTH): bit leaving at the MSB end
  logic [SHW-1:0]   idx_r;    // s - 1: bit leaving at the LSB end
  logic [WIDTH-1:0] sh_data;
  logic             sh_carry;

  assign up_ready = !valid || dn_ready;

  always_comb begin
    s        = '0;
    s[HI:LO] = up_amt[HI:LO];
    idx_l    = ~s + 1'b1;
    idx_r    = s - 1'b1;
    sh_data  = up_data;
    sh_carry = up_carry;
    case (up_mode)
      MODE_SLL: begin
        sh_data = up_data << s;
        if (s != '0) sh_carry = up_data[idx_l];
      end
      MODE_SRL: begin
        sh_data = up_data >> s;
        if (s != '0) sh_carry = up_data[idx_r];
      end
      MODE_SRA: begin
        sh_data = WIDTH'($signed(up_data) >>> s);
        if (s != '0) sh_carry = up_data[idx_r];
      end
      MODE_ROL: begin
        // For s == 0 both halves equal up_data, so the OR is a no-op.
        sh_data = (up_data << s) | (up_data >> idx_l);
        if (s != '0) sh_carry = up_data[idx_l];
      end
      default: begin
        sh_data  = up_data;
        sh_carry = up_carry;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
    end else if (up_ready) begin
      valid <= up_valid;
      if (up_valid) begin
        data  <= sh_data;
        mode  <= up_mode;
        amt   <= up_amt;
        carry <= sh_carry;
        zero  <= (sh_data == '0);
      end
    end
  end

  // Only this stage's slice of up_amt feeds the shift; the rest is forwarded.
  logic unused_amt;
  assign unused_amt = ^up_amt;

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter / rotator with valid/ready flow control.
// The shift amount is split across STAGES stages; each stage shifts by its
// own slice and registers the result, so latency is STAGES cycles and
// throughput one beat per cycle. Bubbles collapse; a stalled output holds.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake
//   in_data, in_amt     operand and shift amount (0..WIDTH-1)
//   in_mode             0=SLL, 1=SRL, 2=SRA, 3=ROL
//   out_valid/out_ready output handshake
//   out_data            result
//   out_carry           last bit shifted/rotated out (0 for amount 0)
//   out_zero            out_data == 0
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SHW-1:0]    in_amt,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_carry,
  output logic              out_zero
);

  // Index 0 is the input side, index STAGES the output side.
  logic             v_a [0:STAGES];
  logic             r_a [0:STAGES];
  logic [WIDTH-1:0] d_a [0:STAGES];
  mode_e            m_a [0:STAGES];
  logic [SHW-1:0]   a_a [0:STAGES];
  logic             c_a [0:STAGES];
  logic             z_a [1:STAGES];

  assign v_a[0]      = in_valid;
  assign d_a[0]      = in_data;
  assign m_a[0]      = mode_e'(in_mode);
  assign a_a[0]      = in_amt;
  assign c_a[0]      = 1'b0;
  assign r_a[STAGES] = out_ready;

  assign in_ready  = r_a[0];
  assign out_valid = v_a[STAGES];
  assign out_data  = d_a[STAGES];
  assign out_carry = c_a[STAGES];
  assign out_zero  = z_a[STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .LO    (grp_lo(SHW, STAGES, i)),
      .HI    (grp_hi(SHW, STAGES, i))
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (v_a[i]),
      .up_ready (r_a[i]),
      .up_data  (d_a[i]),
      .up_mode  (m_a[i]),
      .up_amt   (a_a[i]),
      .up_carry (c_a[i]),
      .dn_ready (r_a[i+1]),
      .valid    (v_a[i+1]),
      .data     (d_a[i+1]),
      .mode     (m_a[i+1]),
      .amt      (a_a[i+1]),
      .carry    (c_a[i+1]),
      .zero     (z_a[i+1])
    );
    // Zero flags of intermediate stages are not needed.
    if (i < STAGES - 1) begin : g_unused_z
      logic unused_z;
      assign unused_z = z_a[i+1];
    end
  end

  // Mode and amount are not needed past the last stage.
  logic unused_tail;
  assign unused_tail = ^{m_a[STAGES], a_a[STAGES]};

endmodule
